// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: a DEPTH-entry FIFO of {pc, instruction} pairs that
// decouples fetch from a stalled decode stage and is squashed on redirects.
module if_id_queue #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       branch,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic [XLEN-1:0]            pc_out,
  output logic [31:0]                instruction,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pcMem_q    [DEPTH];
  logic [31:0]     instrMem_q [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic squash;
  logic enq;
  logic deq;

  assign squash      = flush | branch;
  assign in_ready    = (count_q < CW'(DEPTH));
  assign instr_valid = (count_q != '0);
  assign enq         = in_valid & in_ready & ~squash;
  assign deq         = instr_valid & ~stall & ~squash;
  assign count       = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (squash) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (enq) wrPtr_d = wrPtr_q + PW'(1);
      if (deq) rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (enq) begin
      pcMem_q[wrPtr_q]    <= in_pc;
      instrMem_q[wrPtr_q] <= in_instr;
    end
  end

  always_comb begin
    pc_out      = '0;
    instruction = NOP_INSTR;
    if (count_q != '0) begin
      pc_out      = pcMem_q[rdPtr_q];
      instruction = instrMem_q[rdPtr_q];
    end
  end

endmodule
